// File: rtl/hazard_ctrl_mc.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
// It tracks a multi-cycle MUL/DIV unit and holds a JAL in D for a bounded number of cycles.
module hazard_ctrl_mc #(
  parameter int REG_ADDR_W = 5,
  parameter int V0_REG     = 2,
  parameter int A0_REG     = 4,
  parameter int MULDIV_LAT = 32,
  parameter int JAL_STALL  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs_d,
  input  logic [REG_ADDR_W-1:0] rt_d,
  input  logic [REG_ADDR_W-1:0] rs_e,
  input  logic [REG_ADDR_W-1:0] rt_e,
  input  logic [REG_ADDR_W-1:0] write_reg_e,
  input  logic [REG_ADDR_W-1:0] write_reg_m,
  input  logic [REG_ADDR_W-1:0] write_reg_w,
  input  logic                  sig_reg_write_e,
  input  logic                  sig_reg_write_m,
  input  logic                  sig_reg_write_w,
  input  logic                  sig_mem_to_reg_e,
  input  logic                  sig_mem_to_reg_m,
  input  logic                  sig_branch_d,
  input  logic                  sig_jal_d,
  input  logic                  sig_syscall_d,
  input  logic                  sig_hilo_read_d,
  input  logic                  sig_muldiv_d,
  input  logic                  sig_muldiv_e,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  forward_a_d,
  output logic                  forward_b_d,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_e,
  output logic                  muldiv_busy
);

  localparam int MD_W = $clog2(MULDIV_LAT + 1);
  localparam int JW   = $clog2(JAL_STALL + 1);
  localparam logic [REG_ADDR_W-1:0] V0 = REG_ADDR_W'(V0_REG);
  localparam logic [REG_ADDR_W-1:0] A0 = REG_ADDR_W'(A0_REG);

  logic [MD_W-1:0] md_cnt;
  logic [JW-1:0]   jal_cnt;
  logic lw_stall, br_stall, sc_stall, md_stall, jal_stall, any_stall;

  // Register $0 is hard-wired to zero, so it never produces a dependency.
  function automatic logic hit(input logic [REG_ADDR_W-1:0] src,
                               input logic [REG_ADDR_W-1:0] dst,
                               input logic                  en);
    return en && (src != '0) && (src == dst);
  endfunction

  // When the destination is written by both M and W, the younger M result wins.
  assign forward_a_e = hit(rs_e, write_reg_m, sig_reg_write_m) ? 2'b10 :
                       hit(rs_e, write_reg_w, sig_reg_write_w) ? 2'b01 : 2'b00;
  assign forward_b_e = hit(rt_e, write_reg_m, sig_reg_write_m) ? 2'b10 :
                       hit(rt_e, write_reg_w, sig_reg_write_w) ? 2'b01 : 2'b00;
  assign forward_a_d = hit(rs_d, write_reg_m, sig_reg_write_m);
  assign forward_b_d = hit(rt_d, write_reg_m, sig_reg_write_m);

  assign lw_stall = sig_mem_to_reg_e &
                    (hit(rs_d, write_reg_e, 1'b1) | hit(rt_d, write_reg_e, 1'b1));

  assign br_stall = sig_branch_d &
                    (hit(rs_d, write_reg_e, sig_reg_write_e)  |
                     hit(rt_d, write_reg_e, sig_reg_write_e)  |
                     hit(rs_d, write_reg_m, sig_mem_to_reg_m) |
                     hit(rt_d, write_reg_m, sig_mem_to_reg_m));

  assign sc_stall = sig_syscall_d &
                    (hit(V0, write_reg_e, sig_reg_write_e) | hit(A0, write_reg_e, sig_reg_write_e) |
                     hit(V0, write_reg_m, sig_reg_write_m) | hit(A0, write_reg_m, sig_reg_write_m) |
                     hit(V0, write_reg_w, sig_reg_write_w) | hit(A0, write_reg_w, sig_reg_write_w));

  assign muldiv_busy = (md_cnt != '0);
  assign md_stall    = muldiv_busy & (sig_hilo_read_d | sig_muldiv_d);
  assign jal_stall   = sig_jal_d & (jal_cnt < JW'(JAL_STALL));

  assign any_stall = lw_stall | br_stall | sc_stall | md_stall | jal_stall;
  assign stall_f   = any_stall;
  assign stall_d   = any_stall;
  assign flush_e   = any_stall;

  // A new MUL/DIV restarts the busy window even while an older one is still pending.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= '0;
    end else if (sig_muldiv_e) begin
      md_cnt <= MD_W'(MULDIV_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - MD_W'(1);
    end
  end

  // Counts stalled cycles of the JAL in D, even when another hazard caused the stall.
  // The counter clears as soon as D advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jal_cnt <= '0;
    end else if (sig_jal_d && stall_d) begin
      if (jal_cnt != JW'(JAL_STALL)) jal_cnt <= jal_cnt + JW'(1);
    end else begin
      jal_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: a table of combinational vectors, hand-written multi-cycle sequences,
// and random traffic checked against a timestamp-based reference model.
module tb_hazard_ctrl_mc;

  localparam int MULDIV_LAT = 4;
  localparam int JAL_STALL  = 2;

  typedef struct {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic rw_e, rw_m, rw_w, m2r_e, m2r_m, br_d, jal_d, sc_d, hr_d, md_d, md_e;
  } in_t;

  typedef struct {
    in_t        i;
    logic [9:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  cur;
  logic [1:0] forward_a_e, forward_b_e;
  logic forward_a_d, forward_b_d, stall_f, stall_d, flush_e, muldiv_busy;
  logic [9:0] obs;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: the edge index of the last MUL/DIV issue, and the number of stalled cycles the current JAL has seen.
  int edge_cnt = 0;
  int issue_at = -1000;
  int jal_wait = 0;

  always #5 clk = ~clk;

  hazard_ctrl_mc #(
    .REG_ADDR_W(5), .V0_REG(2), .A0_REG(4),
    .MULDIV_LAT(MULDIV_LAT), .JAL_STALL(JAL_STALL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_d(cur.rs_d), .rt_d(cur.rt_d), .rs_e(cur.rs_e), .rt_e(cur.rt_e),
    .write_reg_e(cur.wr_e), .write_reg_m(cur.wr_m), .write_reg_w(cur.wr_w),
    .sig_reg_write_e(cur.rw_e), .sig_reg_write_m(cur.rw_m), .sig_reg_write_w(cur.rw_w),
    .sig_mem_to_reg_e(cur.m2r_e), .sig_mem_to_reg_m(cur.m2r_m),
    .sig_branch_d(cur.br_d), .sig_jal_d(cur.jal_d), .sig_syscall_d(cur.sc_d),
    .sig_hilo_read_d(cur.hr_d), .sig_muldiv_d(cur.md_d), .sig_muldiv_e(cur.md_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e), .muldiv_busy(muldiv_busy)
  );

  assign obs = {forward_a_e, forward_b_e, forward_a_d, forward_b_d,
                stall_f, stall_d, flush_e, muldiv_busy};

  // Bit layout: {fa_e[1:0], fb_e[1:0], fa_d, fb_d, stall_f, stall_d, flush_e, busy}.
  function automatic logic [9:0] pk(input logic [1:0] fa, input logic [1:0] fb,
                                    input logic ad, input logic bd, input logic st);
    return {fa, fb, ad, bd, st, st, st, 1'b0};
  endfunction

  function automatic logic [9:0] e(input logic st, input logic busy);
    return {6'b0, st, st, st, busy};
  endfunction

  function automatic bit dep(input logic [4:0] src, input logic [4:0] dst, input logic en);
    return en && src != 0 && src == dst;
  endfunction

  function automatic logic [9:0] ref_out(input in_t x);
    logic [1:0] fa, fb;
    bit busy, stall;
    bit [4:0] src_d [2];
    bit [4:0] svc [2];
    busy = (edge_cnt - issue_at) < MULDIV_LAT;
    fa = dep(x.rs_e, x.wr_m, x.rw_m) ? 2'd2 : dep(x.rs_e, x.wr_w, x.rw_w) ? 2'd1 : 2'd0;
    fb = dep(x.rt_e, x.wr_m, x.rw_m) ? 2'd2 : dep(x.rt_e, x.wr_w, x.rw_w) ? 2'd1 : 2'd0;
    src_d[0] = x.rs_d;
    src_d[1] = x.rt_d;
    svc[0] = 5'd2;
    svc[1] = 5'd4;
    stall = 0;
    foreach (src_d[k]) begin
      if (x.m2r_e && dep(src_d[k], x.wr_e, 1'b1)) stall = 1;
      if (x.br_d && (dep(src_d[k], x.wr_e, x.rw_e) || dep(src_d[k], x.wr_m, x.m2r_m))) stall = 1;
    end
    foreach (svc[k])
      if (x.sc_d && (dep(svc[k], x.wr_e, x.rw_e) || dep(svc[k], x.wr_m, x.rw_m) ||
                     dep(svc[k], x.wr_w, x.rw_w))) stall = 1;
    if (busy && (x.hr_d || x.md_d)) stall = 1;
    if (x.jal_d && jal_wait < JAL_STALL) stall = 1;
    return {fa, fb, dep(x.rs_d, x.wr_m, x.rw_m), dep(x.rt_d, x.wr_m, x.rw_m),
            stall, stall, stall, busy};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (fa_e fb_e fa_d fb_d sf sd fe busy)", name, act, exp);
    end
  endtask

  task automatic model_reset();
    issue_at = -1000;
    jal_wait = 0;
  endtask

  // Drive at the falling edge, compare 1 ns later, then advance the model at the rising edge.
  task automatic step(input string name, input in_t x, input logic [9:0] exp);
    logic [9:0] r;
    @(negedge clk);
    cur = x;
    #1;
    check(name, obs, exp);
    r = ref_out(x);
    @(posedge clk);
    edge_cnt++;
    if (x.md_e) issue_at = edge_cnt;
    if (x.jal_d && r[2]) jal_wait = (jal_wait + 1 > JAL_STALL) ? JAL_STALL : jal_wait + 1;
    else jal_wait = 0;
  endtask

  initial begin
    in_t  z, x;
    vec_t tv[$];
    z = '{default: '0};
    cur = z;

    // Each vector is applied from the idle state: MUL/DIV not busy and no JAL in D.
    x = z; tv.push_back('{x, pk(2'd0, 2'd0, 0, 0, 0)});
    x = z; x.rs_e = 8; x.wr_m = 8; x.rw_m = 1; x.wr_w = 8; x.rw_w = 1; tv.push_back('{x, pk(2'd2, 2'd0, 0, 0, 0)});
    x = z; x.rs_e = 0; x.wr_m = 8; x.rw_m = 1; x.wr_w = 8; x.rw_w = 1; tv.push_back('{x, pk(2'd0, 2'd0, 0, 0, 0)});
    x = z; x.rs_e = 8; x.rt_e = 9; x.wr_m = 9; x.rw_m = 1; x.wr_w = 8; x.rw_w = 1; tv.push_back('{x, pk(2'd1, 2'd2, 0, 0, 0)});
    x = z; x.rs_e = 8; x.wr_m = 8; x.rw_m = 0; x.wr_w = 8; x.rw_w = 0; tv.push_back('{x, pk(2'd0, 2'd0, 0, 0, 0)});
    x = z; x.rs_d = 7; x.rt_d = 7; x.wr_m = 7; x.rw_m = 1; tv.push_back('{x, pk(2'd0, 2'd0, 1, 1, 0)});
    x = z; x.m2r_e = 1; x.wr_e = 8; x.rw_e = 1; x.rs_d = 8; tv.push_back('{x, pk(2'd0, 2'd0, 0, 0, 1)});
    x = z; x.m2r_e = 1; x.wr_e = 0; x.rw_e = 1; x.rs_d = 0; tv.push_back('{x, pk(2'd0, 2'd0, 0, 0, 0)});
    x = z; x.br_d = 1; x.rt_d = 5; x.wr_e = 5; x.rw_e = 1; tv.push_back('{x, pk(2'd0, 2'd0, 0, 0, 1)});
    x = z; x.br_d = 1; x.rs_d = 6; x.wr_m = 6; x.rw_m = 1; x.m2r_m = 1; tv.push_back('{x, pk(2'd0, 2'd0, 1, 0, 1)});
    x = z; x.br_d = 1; x.rs_d = 6; x.wr_m = 6; x.rw_m = 1; tv.push_back('{x, pk(2'd0, 2'd0, 1, 0, 0)});
    x = z; x.sc_d = 1; x.wr_w = 2; x.rw_w = 1; tv.push_back('{x, pk(2'd0, 2'd0, 0, 0, 1)});
    x = z; x.sc_d = 1; x.wr_w = 2; x.rw_w = 0; tv.push_back('{x, pk(2'd0, 2'd0, 0, 0, 0)});
    x = z; x.sc_d = 1; x.wr_m = 4; x.rw_m = 1; tv.push_back('{x, pk(2'd0, 2'd0, 0, 0, 1)});
    x = z; x.sc_d = 0; x.wr_e = 2; x.rw_e = 1; tv.push_back('{x, pk(2'd0, 2'd0, 0, 0, 0)});
    x = z; x.hr_d = 1; x.md_d = 1; tv.push_back('{x, pk(2'd0, 2'd0, 0, 0, 0)});

    #12;
    check("reset_state", obs, 10'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[k]) step($sformatf("table_%0d", k), tv[k].i, tv[k].exp);

    // MUL/DIV issue followed by MFHI held in D: stalled for exactly MULDIV_LAT cycles.
    x = z; x.md_e = 1; step("md_issue", x, e(0, 0));
    x = z; x.hr_d = 1;
    for (int k = 1; k <= 5; k++) step($sformatf("md_wait_%0d", k), x, e(k <= 4, k <= 4));

    // A JAL held in D, then a second JAL immediately after it.
    x = z; x.jal_d = 1;
    for (int k = 0; k < 6; k++) step($sformatf("jal_%0d", k), x, e((k % 3) != 2, 0));
    x = z; step("jal_gone", x, e(0, 0));

    // A JAL stalled behind a load-use hazard has already used up its cycles when the load clears.
    x = z; x.jal_d = 1; x.m2r_e = 1; x.wr_e = 8; x.rs_d = 8;
    for (int k = 0; k < 3; k++) step($sformatf("jal_lw_%0d", k), x, e(1, 0));
    x.m2r_e = 0; step("jal_after_lw", x, e(0, 0));
    x = z; step("jal_after_lw_idle", x, e(0, 0));

    // SYSCALL waiting on a $v0 writer in W.
    x = z; x.sc_d = 1; x.wr_w = 2; x.rw_w = 1; step("sc_w", x, e(1, 0));
    x.rw_w = 0; step("sc_w_gone", x, e(0, 0));

    // Asynchronous reset in the middle of a MUL/DIV.
    x = z; x.md_e = 1; step("rst_md_issue", x, e(0, 0));
    x = z; x.hr_d = 1; step("rst_md_run", x, e(1, 1));
    @(negedge clk);
    cur = x;
    #1 check("pre_reset_busy", obs, e(1, 1));
    rst_n = 1'b0;
    #1 check("async_reset", obs, e(0, 0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset_mfhi", x, e(0, 0));

    for (int n = 0; n < 400; n++) begin
      x.rs_d = 5'($urandom_range(0, 9)); x.rt_d = 5'($urandom_range(0, 9));
      x.rs_e = 5'($urandom_range(0, 9)); x.rt_e = 5'($urandom_range(0, 9));
      x.wr_e = 5'($urandom_range(0, 9)); x.wr_m = 5'($urandom_range(0, 9));
      x.wr_w = 5'($urandom_range(0, 9));
      x.rw_e = 1'($urandom); x.rw_m = 1'($urandom); x.rw_w = 1'($urandom);
      x.m2r_e = ($urandom_range(0, 3) == 0); x.m2r_m = ($urandom_range(0, 3) == 0);
      x.br_d = ($urandom_range(0, 3) == 0); x.sc_d = ($urandom_range(0, 3) == 0);
      x.jal_d = ($urandom_range(0, 2) == 0); x.hr_d = ($urandom_range(0, 3) == 0);
      x.md_d = ($urandom_range(0, 5) == 0); x.md_e = ($urandom_range(0, 7) == 0);
      step("random", x, ref_out(x));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
